instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
Program-counter and IF/ID pipeline-register stage of the RISC-V core. It owns the PC and drives the word-aligned fetch address into the combinational instruction memory. It captures the returned instruction, with its PC and PC+4, into the IF/ID register consumed by decode. It also handles pipeline stalls, control-flow redirects (branch/jump from EX) and bubble insertion.

Parameters:
ADDR_WIDTH, 32, width of PC and fetch address.
DATA_WIDTH, 32, instruction width.
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
NOP_INSTR, 32'h0000_0013, encoding driven on if_id_instr_o for bubbles (addi x0,x0,0).

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  synchronous, active-high reset.
stall_i  input  1  hazard unit: hold PC and IF/ID contents.
redirect_i  input  1  EX stage: taken branch/jump this cycle.
redirect_pc_i  input  ADDR_WIDTH  target address for redirect_i.
imem_addr_o  output  ADDR_WIDTH  byte address to instruction memory (equals PC).
imem_instr_i  input  DATA_WIDTH  instruction returned combinationally for imem_addr_o.
if_id_pc_o  output  ADDR_WIDTH  PC of the instruction held in IF/ID.
if_id_pc4_o  output  ADDR_WIDTH  if_id_pc_o + 4.
if_id_instr_o  output  DATA_WIDTH  instruction held in IF/ID.
if_id_valid_o  output  1  1 = IF/ID holds a real instruction; 0 = bubble.
misaligned_o  output  1  one-cycle pulse: last redirect target had bits[1:0] != 0.
fetch_count_o  output  32  number of valid instructions loaded into IF/ID since reset.

Behaviour:
- imem_addr_o = pc_q, combinational from the register. Instruction memory reads with zero latency, so imem_instr_i is sampled in the same cycle.
- Reset (rst_i=1 at the clock edge) values:
  - pc_q = RESET_PC.
  - if_id_pc_o = 0, if_id_pc4_o = 0.
  - if_id_instr_o = NOP_INSTR, if_id_valid_o = 0.
  - misaligned_o = 0, fetch_count_o = 0.
  - Reset overrides every other input, including in mid-stall or mid-redirect.
- Priority per edge: rst_i > redirect_i > stall_i > normal advance.
- Normal advance (no reset, redirect or stall):
  - pc_q <= pc_q + 4.
  - IF/ID <= {pc_q, pc_q+4, imem_instr_i}, valid <= 1.
  - fetch_count_o increments by 1.
- Stall (stall_i=1, redirect_i=0): pc_q, all IF/ID outputs and fetch_count_o hold their values.
- Redirect (redirect_i=1, regardless of stall_i):
  - pc_q <= {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00}; the low two bits are forced to zero.
  - IF/ID <= bubble: instr = NOP_INSTR, valid = 0. if_id_pc_o and if_id_pc4_o hold their previous values. This discards the wrong-path instruction fetched this cycle.
  - fetch_count_o does not increment.
  - misaligned_o <= (redirect_pc_i[1:0] != 0).
- misaligned_o is 0 on every edge without a redirect, so it is a single-cycle registered pulse. The redirect itself still proceeds to the aligned address.
- Arithmetic wrap-around:
  - PC+4 is computed modulo 2^ADDR_WIDTH, so 0xFFFF_FFFC advances to 0x0000_0000 and if_id_pc4_o = 0.
  - fetch_count_o wraps from 0xFFFF_FFFF to 0.
- Back-to-back redirects on consecutive cycles: each one takes effect and IF/ID stays a bubble throughout.
- The first valid IF/ID entry appears one edge after reset deasserts, holding the instruction at RESET_PC.
- No combinational path from any input to any IF/ID output or to imem_addr_o.

Test Plan:
- Reset then run 4 cycles, memory word i = 0x0010_0093 + i: IF/ID shows PC 0, 4, 8, 12 with matching words, valid=1, fetch_count_o = 4; if_id_pc4_o = PC+4 each cycle.
- Stall: assert stall_i for 3 cycles while IF/ID holds PC 8 -> PC, IF/ID and counter all frozen; on release the next IF/ID entry is PC 12.
- Redirect to 0x40 while the PC is at 0x10 -> next edge IF/ID valid=0 with instr 0x0000_0013, imem_addr_o = 0x40; the following edge IF/ID holds PC 0x40 with valid=1.
- Redirect to 0x43 with stall_i=1 simultaneously -> the redirect wins: imem_addr_o = 0x40, misaligned_o = 1 for exactly one cycle, IF/ID bubble.
- Start with RESET_PC = 0xFFFF_FFFC -> first IF/ID entry has PC 0xFFFF_FFFC and pc4 0x0000_0000; the next fetch address is 0x0.
- Assert rst_i during a stall with a redirect pending -> all outputs return to their reset values on that edge and imem_addr_o = RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// PC register and IF/ID pipeline register: fetches from a zero-latency instruction memory,
// with stall hold, EX-stage redirect and bubble insertion.
module instruction_fetch_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_instr_i,
  output logic [ADDR_WIDTH-1:0] if_id_pc_o,
  output logic [ADDR_WIDTH-1:0] if_id_pc4_o,
  output logic [DATA_WIDTH-1:0] if_id_instr_o,
  output logic                  if_id_valid_o,
  output logic                  misaligned_o,
  output logic [31:0]           fetch_count_o
);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_if_id_pc;
  logic [ADDR_WIDTH-1:0] r_if_id_pc4;
  logic [DATA_WIDTH-1:0] r_if_id_instr;
  logic                  r_if_id_valid;
  logic                  r_misaligned;
  logic [31:0]           r_fetch_count;
  logic [ADDR_WIDTH-1:0] w_pc4;
  logic [ADDR_WIDTH-1:0] w_redirect_aligned;

  // PC+4 wraps modulo 2^ADDR_WIDTH by construction of the adder width.
  assign w_pc4              = r_pc + ADDR_WIDTH'(4);
  assign w_redirect_aligned = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc          <= RESET_PC;
      r_if_id_pc    <= '0;
      r_if_id_pc4   <= '0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
      r_misaligned  <= 1'b0;
      r_fetch_count <= '0;
    end else if (redirect_i) begin
      // Squash the wrong-path word fetched this cycle; IF/ID PC fields keep their old values.
      r_pc          <= w_redirect_aligned;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
      r_misaligned  <= |redirect_pc_i[1:0];
    end else begin
      r_misaligned <= 1'b0;
      if (!stall_i) begin
        r_pc          <= w_pc4;
        r_if_id_pc    <= r_pc;
        r_if_id_pc4   <= w_pc4;
        r_if_id_instr <= imem_instr_i;
        r_if_id_valid <= 1'b1;
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  assign imem_addr_o   = r_pc;
  assign if_id_pc_o    = r_if_id_pc;
  assign if_id_pc4_o   = r_if_id_pc4;
  assign if_id_instr_o = r_if_id_instr;
  assign if_id_valid_o = r_if_id_valid;
  assign misaligned_o  = r_misaligned;
  assign fetch_count_o = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: directed steps push expected post-edge state,
// a monitor pops and compares one entry after every clock edge.
`timescale 1ns/1ps
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] rpc = '0;

  logic [31:0] imem_addr, imem_instr, id_pc, id_pc4, id_instr, cnt;
  logic        id_valid, mis;

  logic        w_stall = 1'b0;
  logic        w_redir = 1'b0;
  logic [31:0] w_rpc = '0;
  logic [31:0] w_imem_addr, w_imem_instr, w_id_pc, w_id_pc4, w_id_instr, w_cnt;
  logic        w_id_valid, w_mis;

  always #5 clk = ~clk;

  // Memory word at byte address a is 0x0010_0093 + a/4.
  assign imem_instr   = 32'h0010_0093 + (imem_addr >> 2);
  assign w_imem_instr = 32'h0010_0093 + (w_imem_addr >> 2);

  instruction_fetch_stage #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .redirect_i(redir), .redirect_pc_i(rpc),
    .imem_addr_o(imem_addr), .imem_instr_i(imem_instr),
    .if_id_pc_o(id_pc), .if_id_pc4_o(id_pc4), .if_id_instr_o(id_instr),
    .if_id_valid_o(id_valid), .misaligned_o(mis), .fetch_count_o(cnt)
  );

  instruction_fetch_stage #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0013)
  ) dut_wrap (
    .clk_i(clk), .rst_i(rst), .stall_i(w_stall), .redirect_i(w_redir), .redirect_pc_i(w_rpc),
    .imem_addr_o(w_imem_addr), .imem_instr_i(w_imem_instr),
    .if_id_pc_o(w_id_pc), .if_id_pc4_o(w_id_pc4), .if_id_instr_o(w_id_instr),
    .if_id_valid_o(w_id_valid), .misaligned_o(w_mis), .fetch_count_o(w_cnt)
  );

  typedef struct {
    string       name;
    logic [31:0] addr, pc, pc4, instr, cnt;
    logic        v, m;
    logic        chk2;
    logic [31:0] addr2, pc2, pc42, instr2;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_mis = 0;

  logic        nxt_chk2 = 1'b0;
  logic [31:0] nxt_addr2, nxt_pc2, nxt_pc42, nxt_instr2;

  task automatic chk(input string step, input string field, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s.%s actual=%h required=%h", step, field, act, req);
    end
  endtask

  // Monitor: one expected entry per clock edge, sampled 1ns after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "imem_addr", imem_addr, e.addr);
        chk(e.name, "pc",        id_pc,     e.pc);
        chk(e.name, "pc4",       id_pc4,    e.pc4);
        chk(e.name, "instr",     id_instr,  e.instr);
        chk(e.name, "valid",     {31'd0, id_valid}, {31'd0, e.v});
        chk(e.name, "misalign",  {31'd0, mis},      {31'd0, e.m});
        chk(e.name, "count",     cnt,       e.cnt);
        if (e.chk2) begin
          chk(e.name, "wrap_imem_addr", w_imem_addr, e.addr2);
          chk(e.name, "wrap_pc",        w_id_pc,     e.pc2);
          chk(e.name, "wrap_pc4",       w_id_pc4,    e.pc42);
          chk(e.name, "wrap_instr",     w_id_instr,  e.instr2);
        end
      end
    end
  end

  task automatic set_wrap(input logic [31:0] a, p, p4, i);
    nxt_chk2   = 1'b1;
    nxt_addr2  = a;
    nxt_pc2    = p;
    nxt_pc42   = p4;
    nxt_instr2 = i;
  endtask

  task automatic step(input string name, input logic r, s, rd, input logic [31:0] target,
                      input logic [31:0] a, p, p4, ins, input logic v, m, input logic [31:0] c);
    exp_t e;
    rst = r; stall = s; redir = rd; rpc = target;
    e.name = name; e.addr = a; e.pc = p; e.pc4 = p4; e.instr = ins;
    e.v = v; e.m = m; e.cnt = c;
    e.chk2 = nxt_chk2; e.addr2 = nxt_addr2; e.pc2 = nxt_pc2; e.pc42 = nxt_pc42; e.instr2 = nxt_instr2;
    nxt_chk2 = 1'b0;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    //                  rst stall redir target        addr          pc            pc4           instr         v  m  count
    set_wrap(32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0000_0013);
    step("reset",      1, 0, 0, 32'h0,        32'h0000_0000, 32'h0,        32'h0,        32'h0000_0013, 0, 0, 32'd0);
    set_wrap(32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 32'h4010_0092);
    step("run0",       0, 0, 0, 32'h0,        32'h0000_0004, 32'h0,        32'h4,        32'h0010_0093, 1, 0, 32'd1);
    set_wrap(32'h0000_0004, 32'h0000_0000, 32'h0000_0004, 32'h0010_0093);
    step("run1",       0, 0, 0, 32'h0,        32'h0000_0008, 32'h4,        32'h8,        32'h0010_0094, 1, 0, 32'd2);
    step("run2",       0, 0, 0, 32'h0,        32'h0000_000C, 32'h8,        32'hC,        32'h0010_0095, 1, 0, 32'd3);
    step("run3",       0, 0, 0, 32'h0,        32'h0000_0010, 32'hC,        32'h10,       32'h0010_0096, 1, 0, 32'd4);
    step("stall0",     0, 1, 0, 32'h0,        32'h0000_0010, 32'hC,        32'h10,       32'h0010_0096, 1, 0, 32'd4);
    step("stall1",     0, 1, 0, 32'h0,        32'h0000_0010, 32'hC,        32'h10,       32'h0010_0096, 1, 0, 32'd4);
    step("stall2",     0, 1, 0, 32'h0,        32'h0000_0010, 32'hC,        32'h10,       32'h0010_0096, 1, 0, 32'd4);
    step("release",    0, 0, 0, 32'h0,        32'h0000_0014, 32'h10,       32'h14,       32'h0010_0097, 1, 0, 32'd5);
    step("redir40",    0, 0, 1, 32'h40,       32'h0000_0040, 32'h10,       32'h14,       32'h0000_0013, 0, 0, 32'd5);
    step("after40",    0, 0, 0, 32'h0,        32'h0000_0044, 32'h40,       32'h44,       32'h0010_00A3, 1, 0, 32'd6);
    step("redir43stl", 0, 1, 1, 32'h43,       32'h0000_0040, 32'h40,       32'h44,       32'h0000_0013, 0, 1, 32'd6);
    step("redir80b2b", 0, 0, 1, 32'h80,       32'h0000_0080, 32'h40,       32'h44,       32'h0000_0013, 0, 0, 32'd6);
    step("stallbub",   0, 1, 0, 32'h0,        32'h0000_0080, 32'h40,       32'h44,       32'h0000_0013, 0, 0, 32'd6);
    step("after80",    0, 0, 0, 32'h0,        32'h0000_0084, 32'h80,       32'h84,       32'h0010_00B3, 1, 0, 32'd7);
    step("rstovr",     1, 1, 1, 32'h101,      32'h0000_0000, 32'h0,        32'h0,        32'h0000_0013, 0, 0, 32'd0);
    step("postrst",    0, 0, 0, 32'h0,        32'h0000_0004, 32'h0,        32'h4,        32'h0010_0093, 1, 0, 32'd1);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_vec++;
      n_mis++;
      $display("FAIL drain actual=%0d required=0 pending entries", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
